// File: rtl/imm_ext_stage.sv
// ---------------------------------------------------------------------------
// imm_ext_stage
//
// Registered immediate-extension stage of the decode pipe. Each accepted
// instruction has its opcode (instr[31:26]) decoded into an extension mode.
// The immediate field is extended on the input side. The finished
// {imm, mode, instr} entry then goes into a two-entry skid buffer, made of an
// output register plus one skid register. When the consumer stalls, nothing
// is lost or duplicated, and in_ready never depends combinationally on
// out_ready.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous flush (branch redirect), highest priority
//   in_valid   in   1      in_instr is valid
//   in_ready   out  1      stage can accept (state != FULL)
//   in_instr   in   XLEN   raw instruction word
//   out_valid  out  1      out_* hold a valid entry
//   out_ready  in   1      consumer accepts the out_* entry
//   out_imm    out  XLEN   extended immediate
//   out_mode   out  2      00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH
//   out_instr  out  XLEN   instruction accompanying out_imm
//   stall_cnt  out  CNT_W  saturating count of out_valid & !out_ready cycles
// ---------------------------------------------------------------------------
module imm_ext_stage #(
  parameter int XLEN     = 32,
  parameter int IMM_W    = 16,
  parameter int BR_SHIFT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [1:0]       out_mode,
  output logic [XLEN-1:0]  out_instr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // EMPTY: no entry, HALF: output register valid, FULL: output + skid valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // -------------------------------------------------------------------------
  // Input-side decode and extension
  // -------------------------------------------------------------------------
  logic [5:0]       w_opc;
  logic [IMM_W-1:0] w_field;
  logic [XLEN-1:0]  w_sext;
  logic [XLEN-1:0]  w_zext;
  logic [XLEN-1:0]  w_upper;
  logic [XLEN-1:0]  w_branch;
  logic [XLEN-1:0]  w_new_imm;
  logic [1:0]       w_new_mode;

  assign w_opc    = in_instr[XLEN-1 -: 6];
  assign w_field  = in_instr[IMM_W-1:0];
  assign w_sext   = {{(XLEN-IMM_W){w_field[IMM_W-1]}}, w_field};
  assign w_zext   = {{(XLEN-IMM_W){1'b0}}, w_field};
  assign w_upper  = {w_field, {(XLEN-IMM_W){1'b0}}};
  // Bits shifted past the MSB are simply dropped; the width stays XLEN.
  assign w_branch = w_sext << BR_SHIFT;

  always_comb begin
    w_new_mode = MODE_SIGN;
    w_new_imm  = w_sext;
    case (w_opc)
      6'h0C, 6'h0D, 6'h0E: begin
        w_new_mode = MODE_ZERO;
        w_new_imm  = w_zext;
      end
      6'h0F: begin
        w_new_mode = MODE_UPPER;
        w_new_imm  = w_upper;
      end
      6'h04, 6'h05: begin
        w_new_mode = MODE_BRANCH;
        w_new_imm  = w_branch;
      end
      default: begin
        w_new_mode = MODE_SIGN;
        w_new_imm  = w_sext;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake qualifiers
  // -------------------------------------------------------------------------
  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic (flush overrides every transition)
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) w_state_next = ST_HALF;
        end
        ST_HALF: begin
          if (w_in_fire && !w_out_fire)      w_state_next = ST_FULL;
          else if (!w_in_fire && w_out_fire) w_state_next = ST_EMPTY;
          else                               w_state_next = ST_HALF;
        end
        ST_FULL: begin
          if (w_out_fire) w_state_next = ST_HALF;
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output decode. The handshake flags come from the registered state
  // only. The load enables steer the datapath registers below.
  // -------------------------------------------------------------------------
  logic w_load_out_new;   // output register <- freshly decoded input
  logic w_load_out_skid;  // output register <- skid register
  logic w_load_skid;      // skid register   <- freshly decoded input

  always_comb begin
    in_ready        = (r_state != ST_FULL);
    out_valid       = (r_state != ST_EMPTY);
    w_load_out_new  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: w_load_out_new = w_in_fire;
        ST_HALF: begin
          // If the head leaves in the same cycle, the new entry goes
          // straight to the output register. Otherwise it is parked in the
          // skid register.
          w_load_out_new = w_in_fire & w_out_fire;
          w_load_skid    = w_in_fire & ~w_out_fire;
        end
        ST_FULL:  w_load_out_skid = w_out_fire;
        default: begin
          w_load_out_new  = 1'b0;
          w_load_out_skid = 1'b0;
          w_load_skid     = 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: output register and skid register
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] r_out_imm;
  logic [1:0]      r_out_mode;
  logic [XLEN-1:0] r_out_instr;
  logic [XLEN-1:0] r_skid_imm;
  logic [1:0]      r_skid_mode;
  logic [XLEN-1:0] r_skid_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_imm   <= '0;
      r_out_mode  <= MODE_SIGN;
      r_out_instr <= '0;
    end else if (w_load_out_new) begin
      r_out_imm   <= w_new_imm;
      r_out_mode  <= w_new_mode;
      r_out_instr <= in_instr;
    end else if (w_load_out_skid) begin
      r_out_imm   <= r_skid_imm;
      r_out_mode  <= r_skid_mode;
      r_out_instr <= r_skid_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_imm   <= '0;
      r_skid_mode  <= MODE_SIGN;
      r_skid_instr <= '0;
    end else if (w_load_skid) begin
      r_skid_imm   <= w_new_imm;
      r_skid_mode  <= w_new_mode;
      r_skid_instr <= in_instr;
    end
  end

  assign out_imm   = r_out_imm;
  assign out_mode  = r_out_mode;
  assign out_instr = r_out_instr;

  // -------------------------------------------------------------------------
  // Stall counter: counts back-pressure cycles. Flush does not affect it,
  // so the count survives branch redirects.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [1:0]  out_mode;
  logic [31:0] out_instr;
  logic [15:0] stall_cnt;

  // Second instance with a narrow counter, used to reach saturation quickly.
  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_instr;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_imm;
  logic [1:0]  s_out_mode;
  logic [31:0] s_out_instr;
  logic [3:0]  s_stall_cnt;

  imm_ext_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_mode(out_mode), .out_instr(out_instr),
    .stall_cnt(stall_cnt)
  );

  imm_ext_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_instr(s_in_instr),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_imm(s_out_imm), .out_mode(s_out_mode), .out_instr(s_out_instr),
    .stall_cnt(s_stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference extension computed with plain integer arithmetic.
  function automatic void ref_ext(input logic [31:0] ins,
                                  output logic [31:0] imm, output logic [1:0] mode);
    int unsigned opc;
    longint f, sf, r;
    opc = ins[31:26];
    f   = ins[15:0];
    sf  = (f >= 32768) ? f - 65536 : f;
    if (opc == 12 || opc == 13 || opc == 14) begin
      mode = 2'd1; r = f;
    end else if (opc == 15) begin
      mode = 2'd2; r = f * 65536;
    end else if (opc == 4 || opc == 5) begin
      mode = 2'd3; r = sf * 4;
    end else begin
      mode = 2'd0; r = sf;
    end
    imm = r[31:0];
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [1:0]  mode;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  mode;
    logic [31:0] instr;
  } ent_t;

  vec_t vecs[12];
  ent_t q[$];
  int   m_cnt;

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_instr = '0; s_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic [31:0] ins);
    logic [31:0] e_imm;
    logic [1:0]  e_mode;
    ref_ext(ins, e_imm, e_mode);
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_imm"},   out_imm, e_imm);
    chk({name, "_instr"}, out_instr, ins);
  endtask

  initial begin
    logic [31:0] a, b, c, e_imm;
    logic [1:0]  e_mode;

    vecs[0]  = '{32'h2008FFFC, 32'hFFFFFFFC, 2'd0};  // ADDI
    vecs[1]  = '{32'h3508FFFC, 32'h0000FFFC, 2'd1};  // ORI
    vecs[2]  = '{32'h3C081234, 32'h12340000, 2'd2};  // LUI
    vecs[3]  = '{32'h1109FFFF, 32'hFFFFFFFC, 2'd3};  // BEQ
    vecs[4]  = '{32'h30E08000, 32'h00008000, 2'd1};  // ANDI, no sign ext
    vecs[5]  = '{32'h38018001, 32'h00008001, 2'd1};  // XORI
    vecs[6]  = '{32'h14A00010, 32'h00000040, 2'd3};  // BNE positive
    vecs[7]  = '{32'h10008000, 32'hFFFE0000, 2'd3};  // BEQ most negative
    vecs[8]  = '{32'h8C287FFF, 32'h00007FFF, 2'd0};  // LW max positive
    vecs[9]  = '{32'h20018000, 32'hFFFF8000, 2'd0};  // ADDI min negative
    vecs[10] = '{32'h3C01FFFF, 32'hFFFF0000, 2'd2};  // LUI all ones
    vecs[11] = '{32'hFC000001, 32'h00000001, 2'd0};  // opcode 0x3F -> SIGN

    // ---- reset state (checked while rst_n is still low)
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_instr = '0; s_out_ready = 1'b0;
    #2;
    chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_imm",   out_imm, 32'd0);
    chk("rst_out_mode",  {30'b0, out_mode}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    do_reset();

    // ---- table vectors, back-to-back with out_ready=1 (latency N+1)
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      @(negedge clk);
      if (i == 11) in_valid = 1'b0;
      chk("vec_valid", {31'b0, out_valid}, 32'd1);
      chk("vec_imm",   out_imm, vecs[i].imm);
      chk("vec_mode",  {30'b0, out_mode}, {30'b0, vecs[i].mode});
      chk("vec_instr", out_instr, vecs[i].instr);
      $display("vec %0d instr=%h imm=%h mode=%0d", i, out_instr, out_imm, out_mode);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("vec_drain_valid", {31'b0, out_valid}, 32'd0);

    // ---- stall: A,B,C back-to-back with out_ready=0
    do_reset();
    a = 32'h2008FFFC; b = 32'h3508FFFC; c = 32'h3C081234;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = a;
    @(negedge clk);
    chk("stall_rdy_after_a", {31'b0, in_ready}, 32'd1);
    in_instr = b;
    @(negedge clk);
    chk("stall_rdy_after_b", {31'b0, in_ready}, 32'd0);
    in_instr = c;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_rdy", {31'b0, in_ready}, 32'd0);
      chk("stall_hold_instr", out_instr, a);
    end
    chk("stall_cnt_4", {16'b0, stall_cnt}, 32'd4);
    out_ready = 1'b1;
    chk_out("stall_a", a);
    @(negedge clk);
    chk_out("stall_b", b);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("stall_c", c);
    @(negedge clk);
    chk("stall_empty", {31'b0, out_valid}, 32'd0);
    chk("stall_cnt_final", {16'b0, stall_cnt}, 32'd4);
    $display("stall seq A,B,C done stall_cnt=%0d", stall_cnt);

    // ---- flush while FULL with a same-cycle input
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = a;
    @(negedge clk); in_instr = b;
    @(negedge clk);
    chk("flush_full_rdy", {31'b0, in_ready}, 32'd0);
    flush = 1'b1; in_instr = 32'h3C0DDEAD;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'b0, in_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("flush_stays_empty", {31'b0, out_valid}, 32'd0);
    end
    in_valid = 1'b1; in_instr = 32'h1109FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("flush_after", 32'h1109FFFF);
    $display("flush seq done");

    // ---- asynchronous reset while FULL
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = a;
    @(negedge clk); in_instr = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk("areset_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("areset_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("areset_out_imm",   out_imm, 32'd0);
    chk("areset_out_instr", out_instr, 32'd0);
    chk("areset_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = c;
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("areset_first", c);
    $display("async reset seq done");

    // ---- saturation on the narrow-counter instance
    do_reset();
    s_in_valid = 1'b1; s_in_instr = a;
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      chk("sat_cnt", {28'b0, s_stall_cnt}, (k < 15) ? k : 15);
      @(negedge clk);
    end
    $display("saturation seq done cnt=%0d", s_stall_cnt);

    // ---- randomized traffic against a queue model
    do_reset();
    q.delete();
    m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic iv, ordy, fl, in_fire, out_fire;
      logic [31:0] ins;
      logic [5:0]  opc;
      ent_t e;
      // sample state produced by the previous edge
      chk("rnd_in_ready",  {31'b0, in_ready},  {31'b0, q.size() < 2});
      chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      chk("rnd_stall_cnt", {16'b0, stall_cnt}, m_cnt);
      if (q.size() > 0) begin
        chk("rnd_out_imm",   out_imm, q[0].imm);
        chk("rnd_out_mode",  {30'b0, out_mode}, {30'b0, q[0].mode});
        chk("rnd_out_instr", out_instr, q[0].instr);
      end
      // new stimulus
      case ($urandom_range(0, 8))
        0: opc = 6'h04; 1: opc = 6'h05; 2: opc = 6'h0C; 3: opc = 6'h0D;
        4: opc = 6'h0E; 5: opc = 6'h0F; 6: opc = 6'h08; 7: opc = 6'h23;
        default: opc = 6'($urandom);
      endcase
      ins  = {opc, 26'($urandom)};
      iv   = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < 65);
      fl   = ($urandom_range(0, 99) < 3);
      in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
      // model update for the coming edge
      in_fire  = iv && (q.size() < 2);
      out_fire = (q.size() > 0) && ordy;
      if ((q.size() > 0) && !ordy && (m_cnt < 65535)) m_cnt++;
      if (fl) begin
        q.delete();
      end else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) begin
          ref_ext(ins, e_imm, e_mode);
          e.imm = e_imm; e.mode = e_mode; e.instr = ins;
          q.push_back(e);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;
    $display("random phase done stall_cnt=%0d", stall_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
